// File: rtl/gate_response_checker.sv
// Response checker for a 2-input gate: compares y against TRUTH_TABLE[{a,b}], counts samples/mismatches, reports PASS/FAIL once all four input combinations are covered.
// Optional first-fail capture is built when GATE_CHK_FIRST_FAIL_EN is defined; otherwise first_fail is tied to 0.
module gate_response_checker #(
  parameter logic [3:0] TRUTH_TABLE = 4'b1110,
  parameter int         CNT_W       = 8,
  parameter bit         STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic [1:0]       state,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic [CNT_W+2:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    PASS = 2'b10,
    FAIL = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       cov_q, cov_d;

  logic [1:0] idx;
  logic       exp_y;
  logic       fail;
  logic       take;

  assign idx   = {a, b};
  assign exp_y = TRUTH_TABLE[idx];
  assign fail  = (y != exp_y);
  // start wins over a coincident sample, so a restart never counts that sample
  assign take  = (state_q == RUN) && valid && !start;

  always_comb begin
    state_d    = state_q;
    mismatch_d = 1'b0;
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    cov_d      = cov_q;
    if (start) begin
      state_d   = RUN;
      vec_cnt_d = '0;
      err_cnt_d = '0;
      cov_d     = '0;
    end else if (take) begin
      vec_cnt_d = (vec_cnt_q == CNT_MAX) ? vec_cnt_q : vec_cnt_q + 1'b1;
      cov_d     = cov_q | (4'b0001 << idx);
      if (fail) begin
        err_cnt_d  = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + 1'b1;
        mismatch_d = 1'b1;
      end
      if (STOP_ON_ERR && fail) begin
        state_d = FAIL;
      end else if (cov_d == 4'b1111) begin
        state_d = (err_cnt_d == '0) ? PASS : FAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mismatch_q <= 1'b0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      cov_q      <= '0;
    end else begin
      state_q    <= state_d;
      mismatch_q <= mismatch_d;
      vec_cnt_q  <= vec_cnt_d;
      err_cnt_q  <= err_cnt_d;
      cov_q      <= cov_d;
    end
  end

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic [CNT_W+2:0] first_fail_q, first_fail_d;

  // err_cnt never wraps, so a zero count marks the first fail of the run
  always_comb begin
    first_fail_d = first_fail_q;
    if (start) begin
      first_fail_d = '0;
    end else if (take && fail && (err_cnt_q == '0)) begin
      first_fail_d = {vec_cnt_q, a, b, y};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_q <= '0;
    end else begin
      first_fail_q <= first_fail_d;
    end
  end

  assign first_fail = first_fail_q;
`else
  assign first_fail = '0;
`endif

  assign state    = state_q;
  assign done     = state_q[1];
  assign mismatch = mismatch_q;
  assign vec_cnt  = vec_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign cov      = cov_q;

endmodule
